// File: rtl/local_store.sv
// rtl/local_store.sv - quadword local store with fixed-latency tagged load return
// Stores commit at acceptance; loads flow through a LAT-deep valid/data/tag pipeline.
module local_store #(
  parameter int LS_BYTES = 32768,
  parameter int LAT      = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic [0:31]  req_lsa,
  input  logic [0:127] req_wdata,
  input  logic [0:6]   req_rt_addr,
  input  logic         flush,
  output logic         rsp_valid,
  output logic [0:127] rsp_data,
  output logic [0:6]   rsp_rt_addr,
  output logic         regWr_en_ls
);

  localparam int AW    = $clog2(LS_BYTES);
  localparam int IDX_W = AW - 4;
  localparam int DEPTH = LS_BYTES / 16;
  localparam int IDX_B = 32 - AW;

  logic [IDX_W-1:0] qi;
  logic             st_acc;
  logic             ld_acc;
  logic             unused_lsa_bits;

  logic [0:127] mem [DEPTH];

  logic         pipe_valid [LAT];
  logic [0:127] pipe_data  [LAT];
  logic [0:6]   pipe_tag   [LAT];

  // Bits above the index wrap the address; the low nibble forces quadword alignment.
  assign qi              = req_lsa[IDX_B +: IDX_W];
  assign unused_lsa_bits = ^{req_lsa[0:IDX_B-1], req_lsa[28:31]};

  assign st_acc = req_valid &  req_we & ~flush & ~reset;
  assign ld_acc = req_valid & ~req_we & ~flush;

  always_ff @(posedge clk) begin
    if (st_acc) begin
      mem[qi] <= req_wdata;
    end
  end

  // Stage 0 samples the array at the acceptance edge, so a store from the
  // previous edge is already visible and a store on the next edge is not.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) begin
        pipe_valid[k] <= 1'b0;
        pipe_data[k]  <= '0;
        pipe_tag[k]   <= '0;
      end
    end else begin
      pipe_valid[0] <= ld_acc;
      pipe_data[0]  <= mem[qi];
      pipe_tag[0]   <= req_rt_addr;
      for (int k = 1; k < LAT; k++) begin
        pipe_valid[k] <= pipe_valid[k-1] & ~flush;
        pipe_data[k]  <= pipe_data[k-1];
        pipe_tag[k]   <= pipe_tag[k-1];
      end
    end
  end

  assign rsp_valid   = pipe_valid[LAT-1];
  assign rsp_data    = pipe_data[LAT-1];
  assign rsp_rt_addr = pipe_tag[LAT-1];
  assign regWr_en_ls = pipe_valid[LAT-1];

endmodule

// File: doc/local_store.md
# local_store

Single-ported quadword local store serving the load/store traffic generated by the odd pipe. It accepts one request per cycle carrying a computed local-store address (LSA), performs quadword stores immediately, and returns load data tagged with the destination register address after a fixed pipelined latency, ready for register-file writeback. It sits between the odd pipe's address-generation stage and the register-file write port.

## Interface
- LS_BYTES, default 32768: local store size in bytes; power of two, ≥ 256.
- LAT, default 6: load-to-use latency in cycles; LAT ≥ 1.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_we  in  1  1 = store quadword, 0 = load quadword.
- req_lsa  in  [0:31]  byte address from the odd pipe; bit 0 is MSB.
- req_wdata  in  [0:127]  store data (RT contents); byte 0 = bits [0:7].
- req_rt_addr  in  [0:6]  destination register of a load.
- flush  in  1  kill all in-flight loads (branch redirect).
- rsp_valid  out  1  load data valid this cycle.
- rsp_data  out  [0:127]  loaded quadword.
- rsp_rt_addr  out  [0:6]  destination register for rsp_data.
- regWr_en_ls  out  1  register-file write enable; equals rsp_valid.

## Operation
- Storage: LS_BYTES/16 quadword entries, index QI = req_lsa[32−log2(LS_BYTES) : 27].
- Address rules: req_lsa[28:31] ignored (forced 16-byte alignment, i.e. & 0xFFFFFFF0); bits above the index ignored, so addresses wrap modulo LS_BYTES (LSA = LS_BYTES + 0x10 hits entry 1).
- Store (req_valid & req_we & !flush): entry QI ← req_wdata at the acceptance edge; no response generated.
- Load (req_valid & !req_we & !flush): entry QI read at the acceptance edge; data, req_rt_addr and a valid bit enter a LAT-deep shift pipeline.
- Always ready: no backpressure; one request per cycle, no stall path.
- Flush: at the edge where flush = 1, every pipeline valid bit clears and the request presented that cycle (load or store) is discarded: no array write, no response. Data/tag registers may keep stale values; only valid bits matter.
- Read-after-write: a load accepted the cycle after a store to the same QI returns the new data. One request per cycle means no same-cycle read/write conflict.
- Write-after-read: a load accepted in cycle N followed by a store to the same QI in cycle N+1 returns the old data.
- Response ordering: strictly in request order; no reordering or merging.

## Timing
- Request sampled at the rising edge ending cycle N; load response visible in cycle N+LAT (rsp_valid high for exactly one cycle per load).
- Back-to-back loads give back-to-back responses, one per cycle, full throughput.
- Stores take effect at the acceptance edge; visible to a load in cycle N+1.
- Reset: rsp_valid = 0, regWr_en_ls = 0, rsp_data = 0, rsp_rt_addr = 0 from the edge where reset is sampled high; all pipeline valid bits cleared; array contents not cleared. Requests during reset are ignored (no store).
- Reset mid-operation: in-flight loads dropped, never returned; the first request after reset deasserts behaves normally.
- Flush and reset together: reset dominates; result is identical.
- Outputs are registered; no combinational path from req_* or flush to rsp_*.

## Test plan
- Store 0x00112233_44556677_8899AABB_CCDDEEFF at LSA 0x40, load LSA 0x4C with rt_addr 5 in the next cycle -> rsp_valid exactly LAT cycles later, data matches, rsp_rt_addr = 5, regWr_en_ls = 1 for one cycle.
- Store distinct patterns to LSA 0x0 and 0x10, load LS_BYTES+0x10 and 0xFFFF_FFF0 (LS_BYTES=32768 → entry 0x7FF) -> wrap to entries 1 and 0x7FF; returns entry-1 pattern, then entry-0x7FF contents.
- Eight back-to-back loads, rt_addr 0..7 -> eight consecutive rsp_valid cycles, tags 0..7 in order, no gaps.
- Load to QI 3 in cycle N, store 0xFF.. to QI 3 in N+1 -> load returns old value; a further load in N+2 returns 0xFF...
- Issue 3 loads, assert flush with a store request 2 cycles later -> no rsp_valid for any of the 3 loads, store target unchanged; a load issued after flush returns normally at N+LAT.
- Loads in flight, assert reset one cycle -> all rsp_* zero the next cycle, no stale responses; array data written before reset still readable after.
